// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retirement buffer with out-of-order writeback
module reorder_buffer #(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4,
    parameter int DATA_W = 32,
    parameter int EXC_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    // allocation channel
    input  logic              alloc_en,
    output logic              alloc_ready,
    output logic [IDX_W-1:0]  alloc_id,
    input  logic              alloc_reg_write_add,
    input  logic              alloc_reg_write_en,
    input  logic              alloc_reg_write_lo_en,
    input  logic              alloc_is_delayslot,
    input  logic [4:0]        alloc_reg_write_addr,
    input  logic [EXC_W-1:0]  alloc_exception_type,
    input  logic [DATA_W-1:0] alloc_pc,
    // writeback channel
    input  logic              update_en,
    input  logic [IDX_W-1:0]  update_id,
    input  logic [DATA_W-1:0] update_data,
    input  logic [DATA_W-1:0] update_lo_data,
    input  logic [EXC_W-1:0]  update_exception_type,
    // commit channel
    output logic              commit_valid,
    input  logic              commit_ack,
    output logic [IDX_W-1:0]  commit_id,
    output logic              commit_reg_write_add,
    output logic              commit_reg_write_en,
    output logic [4:0]        commit_reg_write_addr,
    output logic [DATA_W-1:0] commit_reg_write_data,
    output logic              commit_reg_write_lo_en,
    output logic [DATA_W-1:0] commit_reg_write_lo_data,
    output logic [EXC_W-1:0]  commit_exception_type,
    output logic              commit_is_delayslot,
    output logic [DATA_W-1:0] commit_pc,
    output logic [IDX_W:0]    count
);

    localparam logic [IDX_W:0] PTR_ONE = (IDX_W+1)'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [IDX_W:0]    r_head;
    logic [IDX_W:0]    r_tail;
    logic [IDX_W:0]    r_count;

    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_done;
    logic [DEPTH-1:0]  r_rw_add;
    logic [DEPTH-1:0]  r_rw_en;
    logic [DEPTH-1:0]  r_rw_lo_en;
    logic [DEPTH-1:0]  r_delayslot;
    logic [4:0]        r_rw_addr [DEPTH];
    logic [DATA_W-1:0] r_data    [DEPTH];
    logic [DATA_W-1:0] r_lo_data [DEPTH];
    logic [EXC_W-1:0]  r_exc     [DEPTH];
    logic [DATA_W-1:0] r_pc      [DEPTH];

    logic [IDX_W-1:0]  w_head_idx;
    logic [IDX_W-1:0]  w_tail_idx;
    logic              w_full;
    logic              w_alloc_fire;
    logic              w_update_hit;
    logic              w_commit_fire;

    assign w_head_idx = r_head[IDX_W-1:0];
    assign w_tail_idx = r_tail[IDX_W-1:0];

    // Full depends on registered pointers only, so a same-cycle retire never frees a slot.
    assign w_full      = (w_head_idx == w_tail_idx) && (r_head[IDX_W] != r_tail[IDX_W]);
    assign alloc_ready = !w_full;
    assign alloc_id    = w_tail_idx;
    assign count       = r_count;

    assign commit_valid  = r_valid[w_head_idx] && r_done[w_head_idx];
    assign w_alloc_fire  = alloc_en && alloc_ready;
    assign w_commit_fire = commit_valid && commit_ack;

    // A writeback racing an allocation into the same slot belongs to a stale
    // instruction, so the allocation wins.
    assign w_update_hit = update_en && r_valid[update_id]
                          && !(w_alloc_fire && (update_id == w_tail_idx));

    // Head entry is always presented; commit_valid qualifies it.
    assign commit_id                = w_head_idx;
    assign commit_reg_write_add     = r_rw_add[w_head_idx];
    assign commit_reg_write_en      = r_rw_en[w_head_idx];
    assign commit_reg_write_addr    = r_rw_addr[w_head_idx];
    assign commit_reg_write_data    = r_data[w_head_idx];
    assign commit_reg_write_lo_en   = r_rw_lo_en[w_head_idx];
    assign commit_reg_write_lo_data = r_lo_data[w_head_idx];
    assign commit_exception_type    = r_exc[w_head_idx];
    assign commit_is_delayslot      = r_delayslot[w_head_idx];
    assign commit_pc                = r_pc[w_head_idx];

    // Entry storage and pointers: reset > flush > {alloc, update, commit}.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_valid     <= '0;
            r_done      <= '0;
            r_rw_add    <= '0;
            r_rw_en     <= '0;
            r_rw_lo_en  <= '0;
            r_delayslot <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_rw_addr[i] <= '0;
                r_data[i]    <= '0;
                r_lo_data[i] <= '0;
                r_exc[i]     <= '0;
                r_pc[i]      <= '0;
            end
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
            r_done  <= '0;
        end else begin
            if (w_alloc_fire) begin
                r_valid[w_tail_idx]     <= 1'b1;
                r_done[w_tail_idx]      <= (alloc_exception_type != '0);
                r_rw_add[w_tail_idx]    <= alloc_reg_write_add;
                r_rw_en[w_tail_idx]     <= alloc_reg_write_en;
                r_rw_lo_en[w_tail_idx]  <= alloc_reg_write_lo_en;
                r_delayslot[w_tail_idx] <= alloc_is_delayslot;
                r_rw_addr[w_tail_idx]   <= alloc_reg_write_addr;
                r_exc[w_tail_idx]       <= alloc_exception_type;
                r_pc[w_tail_idx]        <= alloc_pc;
                r_data[w_tail_idx]      <= '0;
                r_lo_data[w_tail_idx]   <= '0;
                r_tail                  <= r_tail + PTR_ONE;
            end
            if (w_update_hit) begin
                r_done[update_id]    <= 1'b1;
                r_data[update_id]    <= update_data;
                r_lo_data[update_id] <= update_lo_data;
                r_exc[update_id]     <= update_exception_type;
            end
            if (w_commit_fire) begin
                r_valid[w_head_idx] <= 1'b0;
                r_done[w_head_idx]  <= 1'b0;
                r_head              <= r_head + PTR_ONE;
            end
            r_count <= r_count + (IDX_W+1)'(w_alloc_fire) - (IDX_W+1)'(w_commit_fire);
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - scoreboard bench for reorder_buffer
module tb_reorder_buffer;

    localparam int DEPTH  = 16;
    localparam int IDX_W  = 4;
    localparam int DATA_W = 32;
    localparam int EXC_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              alloc_en;
    logic              alloc_ready;
    logic [IDX_W-1:0]  alloc_id;
    logic              alloc_reg_write_add;
    logic              alloc_reg_write_en;
    logic              alloc_reg_write_lo_en;
    logic              alloc_is_delayslot;
    logic [4:0]        alloc_reg_write_addr;
    logic [EXC_W-1:0]  alloc_exception_type;
    logic [DATA_W-1:0] alloc_pc;
    logic              update_en;
    logic [IDX_W-1:0]  update_id;
    logic [DATA_W-1:0] update_data;
    logic [DATA_W-1:0] update_lo_data;
    logic [EXC_W-1:0]  update_exception_type;
    logic              commit_valid;
    logic              commit_ack;
    logic [IDX_W-1:0]  commit_id;
    logic              commit_reg_write_add;
    logic              commit_reg_write_en;
    logic [4:0]        commit_reg_write_addr;
    logic [DATA_W-1:0] commit_reg_write_data;
    logic              commit_reg_write_lo_en;
    logic [DATA_W-1:0] commit_reg_write_lo_data;
    logic [EXC_W-1:0]  commit_exception_type;
    logic              commit_is_delayslot;
    logic [DATA_W-1:0] commit_pc;
    logic [IDX_W:0]    count;

    reorder_buffer #(.DEPTH(DEPTH), .IDX_W(IDX_W), .DATA_W(DATA_W), .EXC_W(EXC_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_en(alloc_en), .alloc_ready(alloc_ready), .alloc_id(alloc_id),
        .alloc_reg_write_add(alloc_reg_write_add), .alloc_reg_write_en(alloc_reg_write_en),
        .alloc_reg_write_lo_en(alloc_reg_write_lo_en), .alloc_is_delayslot(alloc_is_delayslot),
        .alloc_reg_write_addr(alloc_reg_write_addr), .alloc_exception_type(alloc_exception_type),
        .alloc_pc(alloc_pc),
        .update_en(update_en), .update_id(update_id), .update_data(update_data),
        .update_lo_data(update_lo_data), .update_exception_type(update_exception_type),
        .commit_valid(commit_valid), .commit_ack(commit_ack), .commit_id(commit_id),
        .commit_reg_write_add(commit_reg_write_add), .commit_reg_write_en(commit_reg_write_en),
        .commit_reg_write_addr(commit_reg_write_addr), .commit_reg_write_data(commit_reg_write_data),
        .commit_reg_write_lo_en(commit_reg_write_lo_en), .commit_reg_write_lo_data(commit_reg_write_lo_data),
        .commit_exception_type(commit_exception_type), .commit_is_delayslot(commit_is_delayslot),
        .commit_pc(commit_pc), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              id;
        logic [31:0]     pc;
        logic [4:0]      addr;
        logic            dslot;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_data [DEPTH];
    logic [31:0] m_lo   [DEPTH];
    logic [7:0]  m_exc  [DEPTH];
    int          m_tail;
    int          m_count;
    int          n_cmp;
    int          n_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        flush = 0; alloc_en = 0; commit_ack = 0; update_en = 0;
        alloc_reg_write_add = 0; alloc_reg_write_en = 0; alloc_reg_write_lo_en = 0;
        alloc_is_delayslot = 0; alloc_reg_write_addr = 0; alloc_exception_type = 0; alloc_pc = 0;
        update_id = 0; update_data = 0; update_lo_data = 0; update_exception_type = 0;
    endtask

    task automatic model_flush();
        sb_q.delete();
        m_tail = 0;
        m_count = 0;
    endtask

    // One allocation; returns after the edge that samples it.
    task automatic do_alloc(input logic [31:0] pc, input logic [7:0] exc);
        exp_t e;
        check("alloc_id", 64'(alloc_id), 64'(m_tail));
        alloc_en = 1;
        alloc_pc = pc;
        alloc_exception_type = exc;
        alloc_reg_write_en = 1;
        alloc_reg_write_addr = pc[6:2];
        alloc_is_delayslot = pc[3];
        if (m_count < DEPTH) begin
            e.id = m_tail; e.pc = pc; e.addr = pc[6:2]; e.dslot = pc[3];
            sb_q.push_back(e);
            m_data[m_tail] = 0;
            m_lo[m_tail] = 0;
            m_exc[m_tail] = exc;
            m_tail = (m_tail + 1) % DEPTH;
            m_count++;
        end
        @(negedge clk);
        alloc_en = 0;
        alloc_exception_type = 0;
    endtask

    task automatic do_update(input int id, input logic [31:0] data);
        update_en = 1;
        update_id = IDX_W'(id);
        update_data = data;
        update_lo_data = ~data;
        update_exception_type = 0;
        m_data[id] = data;
        m_lo[id] = ~data;
        m_exc[id] = 0;
        @(negedge clk);
        update_en = 0;
    endtask

    task automatic do_commit();
        exp_t e;
        check("commit_valid", 64'(commit_valid), 64'd1);
        if (sb_q.size() == 0) begin
            check("scoreboard_nonempty", 64'd0, 64'd1);
        end else begin
            e = sb_q.pop_front();
            check("commit_id", 64'(commit_id), 64'(e.id));
            check("commit_pc", 64'(commit_pc), 64'(e.pc));
            check("commit_addr", 64'(commit_reg_write_addr), 64'(e.addr));
            check("commit_dslot", 64'(commit_is_delayslot), 64'(e.dslot));
            check("commit_data", 64'(commit_reg_write_data), 64'(m_data[e.id]));
            check("commit_lo_data", 64'(commit_reg_write_lo_data), 64'(m_lo[e.id]));
            check("commit_exc", 64'(commit_exception_type), 64'(m_exc[e.id]));
            m_count--;
        end
        commit_ack = 1;
        @(negedge clk);
        commit_ack = 0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        idle_inputs();
        model_flush();
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;

        // reset state
        check("rst_alloc_ready", 64'(alloc_ready), 64'd1);
        check("rst_alloc_id", 64'(alloc_id), 64'd0);
        check("rst_commit_valid", 64'(commit_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_commit_pc", 64'(commit_pc), 64'd0);
        check("rst_commit_data", 64'(commit_reg_write_data), 64'd0);

        // basic alloc / update / commit
        do_alloc(32'h100, 8'h00);
        check("basic_not_done", 64'(commit_valid), 64'd0);
        do_update(0, 32'h55);
        check("basic_data", 64'(commit_reg_write_data), 64'h55);
        do_commit();
        check("basic_count", 64'(count), 64'd0);

        // out-of-order completion, in-order retirement
        do_alloc(32'h200, 0); do_alloc(32'h204, 0); do_alloc(32'h208, 0);
        do_update(3, 32'hA2);
        check("ooo_wait_a", 64'(commit_valid), 64'd0);
        do_update(2, 32'hA1);
        check("ooo_wait_b", 64'(commit_valid), 64'd0);
        do_update(1, 32'hA0);
        for (int i = 0; i < 3; i++) do_commit();
        check("ooo_empty_cv", 64'(commit_valid), 64'd0);

        // exception at allocation marks the entry done
        do_alloc(32'h300, 8'h04);
        check("exc_done", 64'(commit_valid), 64'd1);
        check("exc_type", 64'(commit_exception_type), 64'h04);
        do_commit();

        // fill to full, overflow attempt, retire-during-full alloc ignored
        for (int i = 0; i < DEPTH; i++) do_alloc(32'h1000 + 32'(i*4), 0);
        check("full_ready", 64'(alloc_ready), 64'd0);
        check("full_count", 64'(count), 64'd16);
        do_alloc(32'hDEAD, 0);
        check("ovf_count", 64'(count), 64'd16);
        for (int i = 0; i < DEPTH; i++) do_update((5 + i) % DEPTH, 32'hB000 + 32'(i));
        // alloc_en with a retiring ack while full: alloc must be dropped
        alloc_en = 1; alloc_pc = 32'hBEEF;
        do_commit();
        alloc_en = 0;
        check("full_ack_count", 64'(count), 64'd15);
        check("full_ack_ready", 64'(alloc_ready), 64'd1);
        while (sb_q.size() > 0) do_commit();
        check("drain_count", 64'(count), 64'd0);

        // flush back to index 0, then 20 wrapping pairs
        flush = 1; @(negedge clk); flush = 0; model_flush();
        for (int i = 0; i < 20; i++) begin
            do_alloc(32'h4000 + 32'(i*4), 0);
            do_update(sb_q[0].id, 32'hC000 + 32'(i));
            do_commit();
        end
        check("wrap_alloc_id", 64'(alloc_id), 64'd4);

        // update to an invalid entry changes nothing
        do_update(9, 32'h999);
        check("inv_upd_cv", 64'(commit_valid), 64'd0);
        check("inv_upd_count", 64'(count), 64'd0);

        // update colliding with allocation into the tail: allocation wins
        update_en = 1; update_id = 4'd4; update_data = 32'h77;
        do_alloc(32'h5000, 0);
        update_en = 0;
        check("collide_cv", 64'(commit_valid), 64'd0);
        check("collide_data", 64'(commit_reg_write_data), 64'd0);
        do_update(4, 32'h78);
        do_commit();

        // flush overrides concurrent alloc and commit
        for (int i = 0; i < 5; i++) do_alloc(32'h6000 + 32'(i*4), 0);
        do_update(sb_q[0].id, 32'h11);
        check("pre_flush_cv", 64'(commit_valid), 64'd1);
        flush = 1; alloc_en = 1; commit_ack = 1;
        @(negedge clk);
        flush = 0; alloc_en = 0; commit_ack = 0;
        model_flush();
        check("flush_count", 64'(count), 64'd0);
        check("flush_cv", 64'(commit_valid), 64'd0);
        check("flush_alloc_id", 64'(alloc_id), 64'd0);

        // reset mid-operation beats a concurrent allocation and flush
        do_alloc(32'h7000, 8'h02);
        rst = 1; alloc_en = 1; flush = 1;
        @(negedge clk);
        rst = 0; alloc_en = 0; flush = 0;
        model_flush();
        check("rst_mid_count", 64'(count), 64'd0);
        check("rst_mid_cv", 64'(commit_valid), 64'd0);
        check("rst_mid_pc", 64'(commit_pc), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
